dl_mem_arbiter: RTL and testbench

// - Shares one single-port ROM/program BRAM between the HPS loader (ioctl download byte stream) and CPU opcode/data reads.
// - Download bytes are buffered in a small FIFO; CPU reads are normally served first, and buffered writes drain in idle cycles.
// - Sits between hps_io ioctl_* / berzerk core fetch path and the BRAM; also reports download completion and overflow.

---
 rtl/dl_mem_arbiter_pkg.sv | 24 ++
 rtl/dl_mem_arbiter_wr_fifo.sv | 78 +++++++
 rtl/dl_mem_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_dl_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dl_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// berzerk_dl_pkg
// Shared types and defaults for the download/CPU BRAM arbiter.
//   arb_state_t : arbiter FSM states (IDLE, RD)
//   dl_entry_t  : one buffered download byte (address + data)
//   DL_AW       : default BRAM byte-address width
//   DL_ROM_SIZE : default number of accepted download bytes
// -----------------------------------------------------------------------------
package berzerk_dl_pkg;

  localparam int          DL_AW       = 16;
  localparam int unsigned DL_ROM_SIZE = 32'h0001_0000;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RD   = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [DL_AW-1:0] addr;
    logic [7:0]       data;
  } dl_entry_t;

endpackage

// File: rtl/dl_mem_arbiter_wr_fifo.sv
// -----------------------------------------------------------------------------
// dl_wr_fifo
// Small synchronous FIFO holding download bytes until the arbiter finds a
// free BRAM cycle. The head entry is visible combinationally on rd_entry.
// Ports:
//   clk_sys, reset_n : clock, synchronous active-low reset (empties FIFO)
//   push, wr_entry   : enqueue wr_entry (caller guarantees room or a same-edge pop)
//   pop              : dequeue head (caller guarantees non-empty)
//   rd_entry         : current head entry
//   full, empty      : occupancy flags
//   count            : number of stored entries, log2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module dl_wr_fifo
  import berzerk_dl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic                       push,
  input  dl_entry_t                  wr_entry,
  input  logic                       pop,
  output dl_entry_t                  rd_entry,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  dl_entry_t     mem_q [DEPTH];
  dl_entry_t     mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q,  count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once count says they exist.
  always_ff @(posedge clk_sys) begin
    mem_q <= mem_d;
  end

  assign rd_entry = mem_q[rd_ptr_q];
  assign full     = (count_q == (PW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/dl_mem_arbiter.sv
// -----------------------------------------------------------------------------
// dl_mem_arbiter
// Shares one single-port program BRAM between the HPS download byte stream and
// CPU reads. Download bytes are buffered in dl_wr_fifo; CPU reads win unless
// the FIFO is full, and buffered bytes drain in otherwise idle cycles.
// Optional feature macro: DL_CHECKSUM_EN adds dl_sum, the mod-256 sum of all
// bytes written to BRAM since the last dn_active rise.
// Ports:
//   clk_sys, reset_n          : clock, synchronous active-low reset
//   dn_active/dn_wr/dn_addr/dn_data : ioctl download level, strobe, address, byte
//   cpu_rd/cpu_addr           : CPU read request (level, held until cpu_ack)
//   cpu_ack/cpu_dout          : one-cycle ack, read data held until next ack
//   mem_addr/mem_din/mem_we   : registered BRAM port
//   mem_dout                  : BRAM read data, MEM_LAT cycles after mem_addr
//   dl_done                   : pulse when download ended and FIFO drained
//   dl_sum                    : checksum (DL_CHECKSUM_EN only)
//   dl_ovf                    : sticky, a download byte was lost
//
// state | meaning
// IDLE  | grant BRAM: forced write if FIFO full, else CPU read, else drain FIFO
// RD    | CPU read in flight for MEM_LAT+1 cycles; rd_cnt counts down to ack
// -----------------------------------------------------------------------------
module dl_mem_arbiter
  import berzerk_dl_pkg::*;
#(
  parameter int          AW       = DL_AW,
  parameter int unsigned ROM_SIZE = DL_ROM_SIZE,
  parameter int          DEPTH    = 4,
  parameter int          MEM_LAT  = 1
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          dn_active,
  input  logic          dn_wr,
  input  logic [AW-1:0] dn_addr,
  input  logic [7:0]    dn_data,
  input  logic          cpu_rd,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_ack,
  output logic [7:0]    cpu_dout,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  output logic          mem_we,
  input  logic [7:0]    mem_dout,
  output logic          dl_done,
`ifdef DL_CHECKSUM_EN
  output logic [7:0]    dl_sum,
`endif
  output logic          dl_ovf
);

  arb_state_t             state_q, state_d;
  logic [1:0]             rd_cnt_q, rd_cnt_d;
  logic [AW-1:0]          mem_addr_q, mem_addr_d;
  logic [7:0]             mem_din_q, mem_din_d;
  logic                   mem_we_q, mem_we_d;
  logic                   cpu_ack_q, cpu_ack_d;
  logic [7:0]             cpu_dout_q, cpu_dout_d;
  logic                   dn_active_q;
  logic                   dl_pend_q, dl_pend_d;
  logic                   dl_done_q, dl_done_d;
  logic                   dl_ovf_q, dl_ovf_d;
`ifdef DL_CHECKSUM_EN
  logic [7:0]             dl_sum_q, dl_sum_d;
`endif

  logic                   dn_rise;
  logic                   in_range;
  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic                   dn_drop;
  logic [$clog2(DEPTH):0] fifo_count;
  dl_entry_t              wr_entry, head;

  assign dn_rise  = dn_active & ~dn_active_q;
  // Widen to 32 bits so ROM_SIZE == 2**AW accepts every address.
  assign in_range = ({{(32-AW){1'b0}}, dn_addr} < ROM_SIZE);

  // A pop is exactly a BRAM write; only IDLE may write.
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty && (fifo_full || !cpu_rd);
  // A full FIFO still accepts a byte when its head leaves on the same edge.
  assign fifo_push = dn_wr && in_range && (!fifo_full || fifo_pop);
  assign dn_drop   = dn_wr && in_range && fifo_full && !fifo_pop;

  always_comb begin
    wr_entry      = '0;
    wr_entry.addr = DL_AW'(dn_addr);
    wr_entry.data = dn_data;
  end

  dl_wr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .push     (fifo_push),
    .wr_entry (wr_entry),
    .pop      (fifo_pop),
    .rd_entry (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    case (state_q)
      IDLE: begin
        if (!fifo_full && cpu_rd) begin
          state_d  = RD;
          rd_cnt_d = 2'(MEM_LAT);
        end
      end
      RD: begin
        if (rd_cnt_q == 2'd0) state_d  = IDLE;
        else                  rd_cnt_d = rd_cnt_q - 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = 1'b0;
    cpu_ack_d  = 1'b0;
    cpu_dout_d = cpu_dout_q;
    if (fifo_pop) begin
      mem_addr_d = AW'(head.addr);
      mem_din_d  = head.data;
      mem_we_d   = 1'b1;
    end else if (state_q == IDLE && cpu_rd) begin
      mem_addr_d = cpu_addr;
    end
    if (state_q == RD && rd_cnt_q == 2'd0) begin
      cpu_dout_d = mem_dout;
      cpu_ack_d  = 1'b1;
    end

    dl_ovf_d = dl_ovf_q;
    if (dn_rise) dl_ovf_d = 1'b0;
    if (dn_drop) dl_ovf_d = 1'b1;

    dl_pend_d = dl_pend_q;
    dl_done_d = 1'b0;
    if (dn_rise) begin
      dl_pend_d = 1'b1;
    end else if (!dn_active && dl_pend_q && fifo_count == '0) begin
      dl_done_d = 1'b1;
      dl_pend_d = 1'b0;
    end

`ifdef DL_CHECKSUM_EN
    dl_sum_d = dl_sum_q;
    if (dn_rise)       dl_sum_d = 8'h00;
    else if (fifo_pop) dl_sum_d = dl_sum_q + head.data;
`endif
  end

  // State register.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rd_cnt_q    <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_we_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_dout_q  <= '0;
      dn_active_q <= 1'b0;
      dl_pend_q   <= 1'b0;
      dl_done_q   <= 1'b0;
      dl_ovf_q    <= 1'b0;
`ifdef DL_CHECKSUM_EN
      dl_sum_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_we_q    <= mem_we_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_dout_q  <= cpu_dout_d;
      dn_active_q <= dn_active;
      dl_pend_q   <= dl_pend_d;
      dl_done_q   <= dl_done_d;
      dl_ovf_q    <= dl_ovf_d;
`ifdef DL_CHECKSUM_EN
      dl_sum_q    <= dl_sum_d;
`endif
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_we   = mem_we_q;
  assign cpu_ack  = cpu_ack_q;
  assign cpu_dout = cpu_dout_q;
  assign dl_done  = dl_done_q;
  assign dl_ovf   = dl_ovf_q;
`ifdef DL_CHECKSUM_EN
  assign dl_sum   = dl_sum_q;
`endif

endmodule

// File: tb/tb_dl_mem_arbiter.sv
module tb_dl_mem_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        dn_active, dn_wr, cpu_rd;
  logic [15:0] dn_addr, cpu_addr;
  logic [7:0]  dn_data;
  logic        cpu_ack, mem_we, dl_done, dl_ovf;
  logic [7:0]  cpu_dout, mem_din;
  logic [7:0]  mem_dout = 8'h00;
  logic [15:0] mem_addr;
`ifdef DL_CHECKSUM_EN
  logic [7:0]  dl_sum;
`endif

  logic [7:0]  bram [0:65535];
  int          n_pass = 0;
  int          n_total = 0;
  int          we_cnt = 0, ack_cnt = 0, done_cnt = 0;

  always #5 clk_sys = ~clk_sys;

  dl_mem_arbiter #(
    .AW       (16),
    .ROM_SIZE (32'h4000),
    .DEPTH    (4),
    .MEM_LAT  (1)
  ) u_dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .dn_active (dn_active),
    .dn_wr     (dn_wr),
    .dn_addr   (dn_addr),
    .dn_data   (dn_data),
    .cpu_rd    (cpu_rd),
    .cpu_addr  (cpu_addr),
    .cpu_ack   (cpu_ack),
    .cpu_dout  (cpu_dout),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_we    (mem_we),
    .mem_dout  (mem_dout),
    .dl_done   (dl_done),
`ifdef DL_CHECKSUM_EN
    .dl_sum    (dl_sum),
`endif
    .dl_ovf    (dl_ovf)
  );

  // BRAM model, one cycle read latency.
  always @(posedge clk_sys) begin
    if (mem_we) bram[mem_addr] <= mem_din;
    mem_dout <= bram[mem_addr];
  end

  always @(negedge clk_sys) begin
    if (mem_we)  we_cnt++;
    if (cpu_ack) ack_cnt++;
    if (dl_done) done_cnt++;
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_sys);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; dn_active = 1'b0; dn_wr = 1'b0; cpu_rd = 1'b0;
    dn_addr = '0; dn_data = '0; cpu_addr = '0;
    cycles(3);
    n_total++;
    if ({cpu_ack, mem_we, mem_addr, mem_din, cpu_dout, dl_done, dl_ovf} !== 37'd0)
      $display("FAIL reset_outputs got ack=%0b we=%0b addr=%h din=%h dout=%h done=%0b ovf=%0b exp all 0",
               cpu_ack, mem_we, mem_addr, mem_din, cpu_dout, dl_done, dl_ovf);
    else n_pass++;
    reset_n = 1'b1;
    cycles(3);
    n_total++;
    if ({cpu_ack, mem_we, dl_done, dl_ovf} !== 4'd0)
      $display("FAIL reset_release got ack=%0b we=%0b done=%0b ovf=%0b exp 0",
               cpu_ack, mem_we, dl_done, dl_ovf);
    else n_pass++;
  endtask

  task automatic test_idle_read;
    int we0, lat;
    bit seen;
    we0 = we_cnt; lat = 0; seen = 0;
    cpu_addr = 16'h0123; cpu_rd = 1'b1;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(negedge clk_sys);
      if (cpu_ack) begin seen = 1; lat = i; end
    end
    cpu_rd = 1'b0;
    n_total++;
    if (lat !== 3) $display("FAIL rd_latency got=%0d negedges exp=3", lat); else n_pass++;
    n_total++;
    if (cpu_dout !== 8'hA5) $display("FAIL rd_data got=%h exp=a5", cpu_dout); else n_pass++;
    cycles(4);
    n_total++;
    if (cpu_dout !== 8'hA5) $display("FAIL rd_data_hold got=%h exp=a5", cpu_dout); else n_pass++;
    n_total++;
    if (we_cnt - we0 !== 0) $display("FAIL rd_no_write got=%0d exp=0", we_cnt - we0); else n_pass++;
  endtask

  task automatic test_download;
    int we0, d0;
    we0 = we_cnt; d0 = done_cnt;
    dn_active = 1'b1;
    cycles(2);
    for (int i = 0; i < 16; i++) begin
      dn_wr = 1'b1; dn_addr = 16'(i); dn_data = 8'(i);
      cycles(1);
      dn_wr = 1'b0;
      cycles(7);
    end
    n_total++;
    if (done_cnt - d0 !== 0) $display("FAIL dl_early_done got=%0d exp=0", done_cnt - d0); else n_pass++;
    dn_active = 1'b0;
    cycles(6);
    n_total++;
    if (we_cnt - we0 !== 16) $display("FAIL dl_we_count got=%0d exp=16", we_cnt - we0); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_total++;
      if (bram[i] !== 8'(i)) $display("FAIL dl_bram[%0d] got=%h exp=%h", i, bram[i], 8'(i));
      else n_pass++;
    end
    n_total++;
    if (done_cnt - d0 !== 1) $display("FAIL dl_done_once got=%0d exp=1", done_cnt - d0); else n_pass++;
    n_total++;
    if (dl_ovf !== 1'b0) $display("FAIL dl_ovf_clear got=%0b exp=0", dl_ovf); else n_pass++;
`ifdef DL_CHECKSUM_EN
    n_total++;
    if (dl_sum !== 8'h78) $display("FAIL dl_sum got=%h exp=78", dl_sum); else n_pass++;
`endif
  endtask

  task automatic test_contention;
    int we0, ack0, bad_data, d0;
    bram[16'h0200] = 8'h3C;
    dn_active = 1'b1;
    cycles(2);
    we0 = we_cnt; ack0 = ack_cnt; bad_data = 0; d0 = done_cnt;
    cpu_addr = 16'h0200; cpu_rd = 1'b1;
    dn_wr = 1'b1; dn_addr = 16'h0020; dn_data = 8'hC0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_sys);
      if (cpu_ack && cpu_dout !== 8'h3C) bad_data++;
      if (k < 4) begin dn_addr = 16'h0020 + 16'(k); dn_data = 8'hC0 + 8'(k); end
      else dn_wr = 1'b0;
    end
    n_total++;
    if (ack_cnt - ack0 !== 3) $display("FAIL cont_acks got=%0d exp=3", ack_cnt - ack0); else n_pass++;
    n_total++;
    if (we_cnt - we0 !== 1) $display("FAIL cont_forced_write got=%0d exp=1", we_cnt - we0); else n_pass++;
    n_total++;
    if (bad_data !== 0) $display("FAIL cont_rd_data bad_acks=%0d exp=0", bad_data); else n_pass++;
    cpu_rd = 1'b0;
    cycles(10);
    n_total++;
    if (we_cnt - we0 !== 4) $display("FAIL cont_we_total got=%0d exp=4", we_cnt - we0); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (bram[16'h0020 + i] !== 8'hC0 + 8'(i))
        $display("FAIL cont_bram[%0d] got=%h exp=%h", i, bram[16'h0020 + i], 8'hC0 + 8'(i));
      else n_pass++;
    end
    n_total++;
    if (dl_ovf !== 1'b0) $display("FAIL cont_ovf got=%0b exp=0", dl_ovf); else n_pass++;
    dn_active = 1'b0;
    cycles(4);
    n_total++;
    if (done_cnt - d0 !== 1) $display("FAIL cont_done got=%0d exp=1", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_overflow;
    dn_active = 1'b1;
    cycles(2);
    cpu_addr = 16'h0200; cpu_rd = 1'b1;
    dn_wr = 1'b1; dn_addr = 16'h0030; dn_data = 8'hD0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_sys);
      if (k < 5) begin dn_addr = 16'h0030 + 16'(k); dn_data = 8'hD0 + 8'(k); end
      else dn_wr = 1'b0;
    end
    n_total++;
    if (dl_ovf !== 1'b1) $display("FAIL ovf_set got=%0b exp=1", dl_ovf); else n_pass++;
    cpu_rd = 1'b0;
    cycles(10);
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (bram[16'h0030 + i] !== 8'hD0 + 8'(i))
        $display("FAIL ovf_bram[%0d] got=%h exp=%h", i, bram[16'h0030 + i], 8'hD0 + 8'(i));
      else n_pass++;
    end
    n_total++;
    if (bram[16'h0034] !== 8'h00) $display("FAIL ovf_dropped_byte got=%h exp=00", bram[16'h0034]); else n_pass++;
    dn_active = 1'b0;
    cycles(3);
    n_total++;
    if (dl_ovf !== 1'b1) $display("FAIL ovf_sticky got=%0b exp=1", dl_ovf); else n_pass++;
    dn_active = 1'b1;
    cycles(2);
    n_total++;
    if (dl_ovf !== 1'b0) $display("FAIL ovf_clear_on_rise got=%0b exp=0", dl_ovf); else n_pass++;
    dn_active = 1'b0;
    cycles(3);
  endtask

  task automatic test_out_of_range;
    int we0;
    dn_active = 1'b1;
    cycles(2);
    we0 = we_cnt;
    dn_wr = 1'b1; dn_addr = 16'h4000; dn_data = 8'h77;
    cycles(1);
    dn_wr = 1'b0;
    cycles(5);
    n_total++;
    if (we_cnt - we0 !== 0) $display("FAIL oor_no_write got=%0d exp=0", we_cnt - we0); else n_pass++;
    n_total++;
    if (bram[16'h4000] !== 8'h5A) $display("FAIL oor_bram got=%h exp=5a", bram[16'h4000]); else n_pass++;
`ifdef DL_CHECKSUM_EN
    n_total++;
    if (dl_sum !== 8'h00) $display("FAIL oor_sum got=%h exp=00", dl_sum); else n_pass++;
`endif
    dn_wr = 1'b1; dn_addr = 16'h3FFF; dn_data = 8'h66;
    cycles(1);
    dn_wr = 1'b0;
    cycles(5);
    n_total++;
    if (bram[16'h3FFF] !== 8'h66) $display("FAIL edge_addr_bram got=%h exp=66", bram[16'h3FFF]); else n_pass++;
`ifdef DL_CHECKSUM_EN
    n_total++;
    if (dl_sum !== 8'h66) $display("FAIL edge_addr_sum got=%h exp=66", dl_sum); else n_pass++;
`endif
    dn_active = 1'b0;
    cycles(3);
  endtask

  task automatic test_reset_mid_read;
    int we0, ack0, d0;
    dn_active = 1'b1;
    cycles(2);
    cpu_addr = 16'h0123; cpu_rd = 1'b1;
    dn_wr = 1'b1; dn_addr = 16'h0050; dn_data = 8'hEE;
    cycles(1);
    cpu_rd = 1'b0; dn_wr = 1'b0; dn_active = 1'b0; reset_n = 1'b0;
    we0 = we_cnt; ack0 = ack_cnt; d0 = done_cnt;
    cycles(1);
    n_total++;
    if ({cpu_ack, mem_we, mem_addr, mem_din, cpu_dout, dl_done, dl_ovf} !== 37'd0)
      $display("FAIL midrd_outputs got ack=%0b we=%0b addr=%h din=%h dout=%h done=%0b ovf=%0b exp all 0",
               cpu_ack, mem_we, mem_addr, mem_din, cpu_dout, dl_done, dl_ovf);
    else n_pass++;
    reset_n = 1'b1;
    cycles(8);
    n_total++;
    if (ack_cnt - ack0 !== 0) $display("FAIL midrd_no_ack got=%0d exp=0", ack_cnt - ack0); else n_pass++;
    n_total++;
    if (we_cnt - we0 !== 0) $display("FAIL midrd_fifo_empty got=%0d writes exp=0", we_cnt - we0); else n_pass++;
    n_total++;
    if (bram[16'h0050] !== 8'h00) $display("FAIL midrd_bram got=%h exp=00", bram[16'h0050]); else n_pass++;
    n_total++;
    if (done_cnt - d0 !== 0) $display("FAIL midrd_no_done got=%0d exp=0", done_cnt - d0); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) bram[i] = 8'h00;
    bram[16'h0123] = 8'hA5;
    bram[16'h4000] = 8'h5A;
    test_reset();
    test_idle_read();
    test_download();
    test_contention();
    test_overflow();
    test_out_of_range();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
